// File: rtl/clock_step_controller_if.sv
// Control and status bundle for clock_step_controller: run/halt/step requests in,
// processor clock enable and progress status out.
interface clock_step_controller_if #(
   parameter int unsigned CNT_W = 32
);
   logic             run;
   logic             halt;
   logic             step;
   logic [7:0]       step_n;
   logic [3:0]       div_sel;
   logic             cpu_en;
   logic [1:0]       state;
   logic             step_done;
   logic [CNT_W-1:0] cycle_cnt;

   modport master (
      output run, halt, step, step_n, div_sel,
      input  cpu_en, state, step_done, cycle_cnt
   );

   modport slave (
      input  run, halt, step, step_n, div_sel,
      output cpu_en, state, step_done, cycle_cnt
   );
endinterface

// File: rtl/clock_step_controller.sv
// Generates divided one-clk enable pulses for a processor in free-running (RUN)
// or fixed-length burst (STEP) mode, with a lifetime count of issued enables.
module clock_step_controller #(
   parameter int unsigned CNT_W = 32
) (
   input logic                  clk,
   input logic                  rst,
   clock_step_controller_if.slave bus
);

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       pre_cnt_q, pre_cnt_d;
   logic [3:0]       div_q, div_d;
   logic [7:0]       rem_q, rem_d;
   logic             cpu_en_q, cpu_en_d;
   logic             step_done_q, step_done_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic             wrap;

   assign wrap = (pre_cnt_q == div_q);

   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      div_d       = div_q;
      rem_d       = rem_q;
      cpu_en_d    = 1'b0;
      step_done_d = 1'b0;
      case (state_q)
         ST_HALT: begin
            pre_cnt_d = '0;
            if (!bus.halt) begin
               if (bus.run) begin
                  state_d = ST_RUN;
                  div_d   = bus.div_sel;
               end else if (bus.step) begin
                  state_d = ST_STEP;
                  div_d   = bus.div_sel;
                  rem_d   = (bus.step_n == 8'd0) ? 8'd1 : bus.step_n;
               end
            end
         end
         ST_RUN: begin
            // Stop requests take precedence over a coinciding wrap.
            if (bus.halt || !bus.run) begin
               state_d   = ST_HALT;
               pre_cnt_d = '0;
            end else if (wrap) begin
               cpu_en_d  = 1'b1;
               pre_cnt_d = '0;
               div_d     = bus.div_sel;
            end else begin
               pre_cnt_d = pre_cnt_q + 4'd1;
            end
         end
         ST_STEP: begin
            if (bus.halt) begin
               state_d   = ST_HALT;
               pre_cnt_d = '0;
               rem_d     = '0;
            end else if (wrap) begin
               cpu_en_d  = 1'b1;
               pre_cnt_d = '0;
               div_d     = bus.div_sel;
               // Last enable of the burst leaves together with the HALT transition.
               if (rem_q <= 8'd1) begin
                  step_done_d = 1'b1;
                  state_d     = ST_HALT;
                  rem_d       = '0;
               end else begin
                  rem_d = rem_q - 8'd1;
               end
            end else begin
               pre_cnt_d = pre_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d   = ST_HALT;
            pre_cnt_d = '0;
         end
      endcase
      cycle_cnt_d = cpu_en_d ? (cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cycle_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_HALT;
         pre_cnt_q   <= '0;
         div_q       <= '0;
         rem_q       <= '0;
         cpu_en_q    <= 1'b0;
         step_done_q <= 1'b0;
         cycle_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         div_q       <= div_d;
         rem_q       <= rem_d;
         cpu_en_q    <= cpu_en_d;
         step_done_q <= step_done_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign bus.cpu_en    = cpu_en_q;
   assign bus.state     = state_q;
   assign bus.step_done = step_done_q;
   assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Self-checking bench for clock_step_controller: vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_clock_step_controller;

   localparam int unsigned CNT_W = 32;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   clock_step_controller_if #(.CNT_W(CNT_W)) bus ();

   clock_step_controller #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: counts cycles since the last enable against the latched period.
   int               m_mode;   // 0 halt, 1 run, 2 step (also the expected state code)
   int               m_since;
   int               m_period;
   int               m_left;
   logic             m_en;
   logic             m_done;
   logic [CNT_W-1:0] m_cnt;

   task automatic model_step();
      m_en   = 1'b0;
      m_done = 1'b0;
      if (rst) begin
         m_mode = 0; m_since = 0; m_period = 1; m_left = 0; m_cnt = '0;
      end else if (m_mode == 0) begin
         if (!bus.halt && bus.run) begin
            m_mode = 1; m_since = 0; m_period = int'(bus.div_sel) + 1;
         end else if (!bus.halt && bus.step) begin
            m_mode = 2; m_since = 0; m_period = int'(bus.div_sel) + 1;
            m_left = (bus.step_n == 8'd0) ? 1 : int'(bus.step_n);
         end
      end else if (bus.halt || (m_mode == 1 && !bus.run)) begin
         m_mode = 0; m_since = 0; m_left = 0;
      end else begin
         m_since = m_since + 1;
         if (m_since == m_period) begin
            m_en = 1'b1; m_since = 0; m_period = int'(bus.div_sel) + 1;
            if (m_mode == 2) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_done = 1'b1; m_mode = 0;
               end
            end
         end
      end
      if (m_en) m_cnt = m_cnt + 1;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic [1:0] st, input logic en,
                          input logic done, input logic [CNT_W-1:0] cnt);
      chk({name, ".state"}, 64'(bus.state), 64'(st));
      chk({name, ".cpu_en"}, 64'(bus.cpu_en), 64'(en));
      chk({name, ".step_done"}, 64'(bus.step_done), 64'(done));
      chk({name, ".cycle_cnt"}, 64'(bus.cycle_cnt), 64'(cnt));
   endtask

   task automatic set_in(input logic r, input logic ru, input logic h, input logic s,
                         input logic [7:0] sn, input logic [3:0] ds);
      rst = r; bus.run = ru; bus.halt = h; bus.step = s; bus.step_n = sn; bus.div_sel = ds;
   endtask

   task automatic do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
      cycle();
      rst = 1'b0;
   endtask

   typedef struct {
      logic       rst, run, halt, step;
      logic [7:0] step_n;
      logic [3:0] div_sel;
      logic [1:0] e_state;
      logic       e_en, e_done;
      int         e_cnt;
   } vec_t;

   vec_t vecs[17];

   initial begin
      n_checks = 0;
      n_errors = 0;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
      m_mode = 0; m_since = 0; m_period = 1; m_left = 0; m_cnt = '0; m_en = 0; m_done = 0;

      //          rst   run   halt  step  step_n div  state  en    done  cnt
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'b00, 1'b0, 1'b0, 0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 4'd0, 2'b00, 1'b0, 1'b0, 0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'b00, 1'b0, 1'b0, 0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 4'd0, 2'b00, 1'b0, 1'b0, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 2'b10, 1'b0, 1'b0, 0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'b00, 1'b1, 1'b1, 1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 2'b01, 1'b0, 1'b0, 1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 2'b01, 1'b1, 1'b0, 2};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 4'd0, 2'b01, 1'b1, 1'b0, 3};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 2'b00, 1'b0, 1'b0, 3};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 4'd1, 2'b10, 1'b0, 1'b0, 3};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd1, 2'b10, 1'b0, 1'b0, 3};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 4'd1, 2'b10, 1'b1, 1'b0, 4};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd1, 2'b10, 1'b0, 1'b0, 4};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd1, 2'b00, 1'b0, 1'b0, 4};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd1, 2'b00, 1'b0, 1'b0, 4};

      #2;
      for (int i = 0; i < 17; i++) begin
         set_in(vecs[i].rst, vecs[i].run, vecs[i].halt, vecs[i].step,
                vecs[i].step_n, vecs[i].div_sel);
         cycle();
         chk_out($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_en, vecs[i].e_done,
                 CNT_W'(vecs[i].e_cnt));
      end

      // Free run, div_sel=3: enables on cycles 4, 8, 12 after RUN appears.
      do_reset();
      bus.run = 1'b1; bus.div_sel = 4'd3;
      cycle();
      chk_out("run_entry", 2'b01, 1'b0, 1'b0, '0);
      for (int k = 1; k <= 12; k++) begin
         cycle();
         chk($sformatf("run_div3.en%0d", k), 64'(bus.cpu_en), 64'((k % 4) == 0));
      end
      chk_out("run_div3_end", 2'b01, 1'b1, 1'b0, CNT_W'(3));

      // Burst of 3 with div_sel=1: pulses 2 cycles apart, done with the third.
      do_reset();
      bus.step = 1'b1; bus.step_n = 8'd3; bus.div_sel = 4'd1;
      cycle();
      bus.step = 1'b0;
      chk_out("step3_entry", 2'b10, 1'b0, 1'b0, '0);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         chk_out($sformatf("step3.c%0d", k), (k == 6) ? 2'b00 : 2'b10, (k % 2) == 0,
                 k == 6, CNT_W'(k / 2));
      end
      cycle();
      chk_out("step3_after", 2'b00, 1'b0, 1'b0, CNT_W'(3));

      // Halt coinciding with a wrap suppresses the enable.
      do_reset();
      bus.run = 1'b1; bus.div_sel = 4'd2;
      cycle();
      cycle();
      cycle();
      chk_out("halt_pre", 2'b01, 1'b0, 1'b0, '0);
      bus.halt = 1'b1;
      cycle();
      chk_out("halt_at_wrap", 2'b00, 1'b0, 1'b0, '0);
      bus.halt = 1'b0; bus.run = 1'b0;

      // Ratio change mid-run only takes effect at the next wrap.
      do_reset();
      bus.run = 1'b1; bus.div_sel = 4'd0;
      cycle();
      for (int k = 1; k <= 3; k++) begin
         cycle();
         chk($sformatf("div0.en%0d", k), 64'(bus.cpu_en), 64'(1));
      end
      bus.div_sel = 4'd3;
      cycle();
      chk_out("div_change_wrap", 2'b01, 1'b1, 1'b0, CNT_W'(4));
      for (int k = 1; k <= 8; k++) begin
         cycle();
         chk($sformatf("div3.en%0d", k), 64'(bus.cpu_en), 64'((k % 4) == 0));
      end
      chk("div3.cnt", 64'(bus.cycle_cnt), 64'(6));
      bus.run = 1'b0;

      // Reset mid-burst aborts everything.
      do_reset();
      bus.step = 1'b1; bus.step_n = 8'd5; bus.div_sel = 4'd0;
      cycle();
      bus.step = 1'b0;
      cycle();
      cycle();
      chk_out("burst5_mid", 2'b10, 1'b1, 1'b0, CNT_W'(2));
      rst = 1'b1;
      cycle();
      chk_out("burst5_rst", 2'b00, 1'b0, 1'b0, '0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk_out($sformatf("burst5_post%0d", k), 2'b00, 1'b0, 1'b0, '0);
      end

      // Randomized traffic against the reference model.
      begin
         logic prev_done;
         prev_done = 1'b0;
         for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            bus.halt = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 29) == 0) bus.run = ~bus.run;
            bus.step   = ($urandom_range(0, 5) == 0);
            bus.step_n = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0)
               bus.div_sel = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                                         : 4'($urandom_range(0, 15));
            cycle();
            chk_out("rand", 2'(m_mode), m_en, m_done, m_cnt);
            chk("rand.done_needs_en", 64'(bus.step_done & ~bus.cpu_en), 64'(0));
            chk("rand.done_twice", 64'(bus.step_done & prev_done), 64'(0));
            prev_done = bus.step_done;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
